// File: rtl/dimmer_controller.sv
// Four-level dimmer FSM driving a frequency divider; optional breathe sequencing under DIMMER_BREATHE_EN.
// Outputs registered, one-cycle latency from the button edge or tick wrap; no backpressure (cs is a fire-and-forget load strobe).
module dimmer_controller #(
    parameter int unsigned STEP_TICKS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       mode_auto,
    output logic [1:0] state_select,
    output logic       cs,
    output logic [1:0] level,
    output logic       at_limit
);

    typedef enum logic [1:0] {IDLE, MANUAL, BREATHE_UP, BREATHE_DN} state_t;

    state_t     state_q, state_d;
    logic [1:0] level_q, level_d;
    logic [1:0] sel_q;
    logic       cs_q, cs_d;
    logic       lim_q;
    logic       up_q, dn_q;
    logic       up_req, dn_req;

    // Duty code for on-counts 1, 2, 4, 7 out of 16.
    function automatic logic [1:0] sel_of(input logic [1:0] lvl);
        case (lvl)
            2'd0:    sel_of = 2'b01;
            2'd1:    sel_of = 2'b00;
            2'd2:    sel_of = 2'b10;
            default: sel_of = 2'b11;
        endcase
    endfunction

    assign up_req = btn_up & ~up_q;
    assign dn_req = btn_dn & ~dn_q;

`ifdef DIMMER_BREATHE_EN
    localparam logic [15:0] LAST_TICK = 16'(STEP_TICKS - 1);
    logic [15:0] tick_q, tick_d;
`else
    logic [16:0] unused_cfg;
    assign unused_cfg = {mode_auto, 16'(STEP_TICKS)};
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cs_d    = 1'b0;
`ifdef DIMMER_BREATHE_EN
        tick_d  = tick_q;
`endif
        if (!enable) begin
            state_d = IDLE;
`ifdef DIMMER_BREATHE_EN
            tick_d  = 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cs_d    = 1'b1;
                    state_d = MANUAL;
`ifdef DIMMER_BREATHE_EN
                    if (mode_auto) begin
                        state_d = BREATHE_UP;
                        tick_d  = 16'd0;
                    end
`endif
                end
                MANUAL: begin
`ifdef DIMMER_BREATHE_EN
                    if (mode_auto) begin
                        state_d = BREATHE_UP;
                        tick_d  = 16'd0;
                    end else
`endif
                    if (up_req && !dn_req && level_q != 2'd3) begin
                        level_d = level_q + 2'd1;
                        cs_d    = 1'b1;
                    end else if (dn_req && !up_req && level_q != 2'd0) begin
                        level_d = level_q - 2'd1;
                        cs_d    = 1'b1;
                    end
                end
`ifdef DIMMER_BREATHE_EN
                BREATHE_UP, BREATHE_DN: begin
                    if (!mode_auto) begin
                        state_d = MANUAL;
                    end else if (tick_q == LAST_TICK) begin
                        tick_d = 16'd0;
                        cs_d   = 1'b1;
                        // At the end stop, the step reverses instead of saturating.
                        if (state_q == BREATHE_UP) begin
                            if (level_q == 2'd3) begin
                                level_d = 2'd2;
                                state_d = BREATHE_DN;
                            end else begin
                                level_d = level_q + 2'd1;
                                if (level_q == 2'd2) state_d = BREATHE_DN;
                            end
                        end else begin
                            if (level_q == 2'd0) begin
                                level_d = 2'd1;
                                state_d = BREATHE_UP;
                            end else begin
                                level_d = level_q - 2'd1;
                                if (level_q == 2'd1) state_d = BREATHE_UP;
                            end
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= 2'd3;
            sel_q   <= 2'b11;
            cs_q    <= 1'b0;
            lim_q   <= 1'b1;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            sel_q   <= sel_of(level_d);
            cs_q    <= cs_d;
            lim_q   <= (level_d == 2'd0) || (level_d == 2'd3);
            up_q    <= btn_up;
            dn_q    <= btn_dn;
        end
    end

`ifdef DIMMER_BREATHE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_q <= 16'd0;
        else     tick_q <= tick_d;
    end
`endif

    assign state_select = sel_q;
    assign cs           = cs_q;
    assign level        = level_q;
    assign at_limit     = lim_q;

endmodule

// File: tb/tb_dimmer_controller.sv
// Directed bench for dimmer_controller; breathe checks run only when DIMMER_BREATHE_EN is defined.
module tb_dimmer_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable, btn_up, btn_dn, mode_auto;
    logic [1:0] state_select, level;
    logic       cs, at_limit;

    int checks   = 0;
    int failures = 0;

    dimmer_controller #(.STEP_TICKS(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .btn_up(btn_up), .btn_dn(btn_dn),
        .mode_auto(mode_auto), .state_select(state_select), .cs(cs),
        .level(level), .at_limit(at_limit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] lv, input logic [1:0] sel,
                           input logic c, input logic lim);
        chk({tag, ".level"}, {2'b00, level}, {2'b00, lv});
        chk({tag, ".sel"}, {2'b00, state_select}, {2'b00, sel});
        chk({tag, ".cs"}, {3'b000, cs}, {3'b000, c});
        chk({tag, ".lim"}, {3'b000, at_limit}, {3'b000, lim});
    endtask

    task automatic press(input logic up, input logic dn, input string tag,
                         input logic [1:0] lv, input logic [1:0] sel, input logic c, input logic lim);
        btn_up = up;
        btn_dn = dn;
        tick();
        chk_out(tag, lv, sel, c, lim);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        tick();
        chk({tag, ".cs_off"}, {3'b000, cs}, 4'd0);
    endtask

`ifdef DIMMER_BREATHE_EN
    logic [1:0] seq [7] = '{2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [1:0] sel_exp;
`endif

    initial begin
        rst = 1'b1; enable = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; mode_auto = 1'b0;
        #3;
        chk_out("reset", 2'd3, 2'b11, 1'b0, 1'b1);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_out("idle", 2'd3, 2'b11, 1'b0, 1'b1);

        enable = 1'b1;
        tick();
        chk_out("enter_manual", 2'd3, 2'b11, 1'b1, 1'b1);
        tick();
        chk("enter_cs_single", {3'b000, cs}, 4'd0);
        tick();
        chk("manual_quiet", {3'b000, cs}, 4'd0);

        press(1'b0, 1'b1, "dn1", 2'd2, 2'b10, 1'b1, 1'b0);
        press(1'b0, 1'b1, "dn2", 2'd1, 2'b00, 1'b1, 1'b0);
        press(1'b0, 1'b1, "dn3", 2'd0, 2'b01, 1'b1, 1'b1);
        press(1'b0, 1'b1, "dn4_sat", 2'd0, 2'b01, 1'b0, 1'b1);
        press(1'b0, 1'b1, "dn5_sat", 2'd0, 2'b01, 1'b0, 1'b1);

        press(1'b1, 1'b0, "up1", 2'd1, 2'b00, 1'b1, 1'b0);
        press(1'b1, 1'b1, "both", 2'd1, 2'b00, 1'b0, 1'b0);

        btn_up = 1'b1;
        tick();
        chk_out("held_first", 2'd2, 2'b10, 1'b1, 1'b0);
        tick();
        chk_out("held_second", 2'd2, 2'b10, 1'b0, 1'b0);
        btn_up = 1'b0;
        tick();

        btn_dn = 1'b1;
        tick();
        chk_out("pre_rst", 2'd1, 2'b00, 1'b1, 1'b0);
        btn_dn = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 2'd3, 2'b11, 1'b0, 1'b1);
        #2 rst = 1'b0;
        tick();
        chk_out("post_rst_enter", 2'd3, 2'b11, 1'b1, 1'b1);
        tick();

        enable = 1'b0;
        tick();
        chk("disable_cs", {3'b000, cs}, 4'd0);
        btn_dn = 1'b1;
        tick();
        chk_out("idle_btn_ignored", 2'd3, 2'b11, 1'b0, 1'b1);
        btn_dn = 1'b0;
        enable = 1'b1;
        tick();
        chk_out("reenable", 2'd3, 2'b11, 1'b1, 1'b1);
        tick();

`ifdef DIMMER_BREATHE_EN
        mode_auto = 1'b1;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk_out("breathe_enter", 2'd3, 2'b11, 1'b1, 1'b1);
        for (int s = 0; s < 7; s++) begin
            for (int t = 0; t < 3; t++) begin
                tick();
                chk("breathe_gap_cs", {3'b000, cs}, 4'd0);
            end
            tick();
            case (seq[s])
                2'd0: sel_exp = 2'b01;
                2'd1: sel_exp = 2'b00;
                2'd2: sel_exp = 2'b10;
                default: sel_exp = 2'b11;
            endcase
            chk_out("breathe_step", seq[s], sel_exp, 1'b1,
                    (seq[s] == 2'd0) || (seq[s] == 2'd3));
        end
        repeat (3) tick();
        btn_up = 1'b1;
        tick();
        chk_out("breathe_to_1", 2'd1, 2'b00, 1'b1, 1'b0);
        btn_up = 1'b0;
        enable = 1'b0;
        tick();
        chk_out("breathe_idle", 2'd1, 2'b00, 1'b0, 1'b0);
        repeat (5) tick();
        chk_out("breathe_idle_hold", 2'd1, 2'b00, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        chk_out("breathe_reenter", 2'd1, 2'b00, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            chk("reenter_gap", {2'b00, level}, 4'd1);
        end
        tick();
        chk_out("reenter_step_up", 2'd2, 2'b10, 1'b1, 1'b0);
        mode_auto = 1'b0;
        tick();
        press(1'b0, 1'b1, "auto_to_manual", 2'd1, 2'b00, 1'b1, 1'b0);
`else
        mode_auto = 1'b1;
        repeat (10) tick();
        chk_out("mode_auto_ignored", 2'd3, 2'b11, 1'b0, 1'b1);
        press(1'b0, 1'b1, "manual_with_auto", 2'd2, 2'b10, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
